// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory, holds the CPU in reset while loading,
// then runs it for RUN_CYCLES clocks. Optional feature macro: BOOT_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start_i, CPU held in reset
// LOAD   | accepting words into instruction memory, CPU held in reset
// RUN    | CPU released, run timer counting down
// DONE   | run budget spent, CPU stays released, results may be sampled
module imem_boot_loader #(
   parameter int ADDR_W     = 5,
   parameter int RUN_CYCLES = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [31:0]       word_i,
   input  logic              word_valid_i,
   input  logic              last_i,
   output logic              word_ready_o,
   output logic              im_we_o,
   output logic [ADDR_W-1:0] im_widx_o,
   output logic [31:0]       im_wdata_o,
   output logic              cpu_rst_n_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   load_count_o,
   output logic              trunc_o,
   output logic [31:0]       chk_sum_o
);

   localparam int RC_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_INIT = RC_W'(RUN_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wp_q, wp_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              trunc_q, trunc_d;
   logic [RC_W-1:0]   rc_q, rc_d;
   logic              accept;
   logic              wp_full;
   logic              clear;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wp_q    <= '0;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
         rc_q    <= rc_d;
      end
   end

   assign word_ready_o = (state_q == S_LOAD) & ~rst_i;
   assign accept       = word_valid_i & word_ready_o;
   assign wp_full      = &wp_q;
   assign clear        = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      cnt_d   = cnt_q;
      trunc_d = trunc_q;
      rc_d    = rc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_LOAD;
               wp_d    = '0;
               cnt_d   = '0;
               trunc_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               // pointer saturates at the top index so it never wraps onto word 0
               if (!wp_full) wp_d = wp_q + 1'b1;
               if (last_i) begin
                  state_d = S_RUN;
                  rc_d    = RC_INIT;
               end else if (wp_full) begin
                  state_d = S_RUN;
                  trunc_d = 1'b1;
                  rc_d    = RC_INIT;
               end
            end
         end
         S_RUN: begin
            if (rc_q == '0) state_d = S_DONE;
            else            rc_d    = rc_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign im_we_o      = accept;
   assign im_widx_o    = wp_q;
   assign im_wdata_o   = word_i;
   assign cpu_rst_n_o  = (state_q == S_RUN) || (state_q == S_DONE);
   assign busy_o       = (state_q == S_LOAD) || (state_q == S_RUN);
   assign done_o       = (state_q == S_DONE);
   assign load_count_o = cnt_q;
   assign trunc_o      = trunc_q;

`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) sum_q <= '0;
      else       sum_q <= sum_d;
   end

   always_comb begin
      sum_d = sum_q;
      if (clear)       sum_d = '0;
      else if (accept) sum_d = sum_q + word_i;
   end

   assign chk_sum_o = sum_q;
`else
   assign chk_sum_o = '0;
`endif

endmodule
